// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - programmable up/down modulo counter with wrap/saturate and tc pulse
// Optional feature macro: PRESCALER_EN (adds prescale input and enabled-cycle prescaler)
module prog_mod_counter #(
  parameter int NBIT        = 8,
  parameter int DEFAULT_MAX = 30,
  parameter int PRESCALE_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  load,
  input  logic [NBIT-1:0]       load_value,
  input  logic                  max_we,
  input  logic [NBIT-1:0]       max_value,
  input  logic                  dir_up,
  input  logic                  wrap_mode,
`ifdef PRESCALER_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [NBIT-1:0]       count,
  output logic                  tc,
  output logic                  halted
);

  localparam logic [NBIT-1:0] RST_MAX = NBIT'(DEFAULT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  logic [NBIT-1:0] max_r;
  logic [NBIT-1:0] eff_max;
  logic [NBIT-1:0] load_clamped;
  logic            at_term;
  logic            shrink;
  logic            step;

  // A MAX write takes effect for load clamping and terminal detection in the same cycle
  assign eff_max      = max_we ? max_value : max_r;
  assign load_clamped = (load_value > eff_max) ? eff_max : load_value;
  assign at_term      = dir_up ? (count >= eff_max) : (count == '0);
  assign shrink       = max_we && (count > max_value);

`ifdef PRESCALER_EN
  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PRESCALE_W-1:0] presc_lat;
  logic [PRESCALE_W-1:0] presc_div;
  logic                  presc_clr;

  // The divisor is resampled at the start of every prescaler period
  assign presc_div = (presc_cnt == '0) ? prescale : presc_lat;
  assign presc_clr = clear || load || (state == HALT);
  assign step      = enable && (presc_cnt == presc_div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
      presc_lat <= '0;
    end else if (presc_clr) begin
      presc_cnt <= '0;
      presc_lat <= '0;
    end else if (enable) begin
      if (presc_cnt == '0) presc_lat <= prescale;
      if (step) presc_cnt <= '0;
      else      presc_cnt <= presc_cnt + 1'b1;
    end
  end
`else
  assign step = enable;
  if (PRESCALE_W < 1) begin : g_prescale_w_unused
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      max_r  <= RST_MAX;
      tc     <= 1'b0;
      halted <= 1'b0;
      state  <= IDLE;
    end else begin
      tc <= 1'b0;
      if (max_we) max_r <= max_value;
      if (clear || load) begin
        count  <= clear ? '0 : load_clamped;
        state  <= enable ? RUN : IDLE;
        halted <= 1'b0;
      end else if (state == HALT) begin
        if (shrink) count <= max_value;
      end else begin
        state <= enable ? RUN : IDLE;
        if (shrink) begin
          count <= max_value;
        end else if (step) begin
          if (at_term) begin
            tc <= 1'b1;
            if (wrap_mode) begin
              count <= dir_up ? '0 : eff_max;
            end else begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end else begin
            count <= dir_up ? count + 1'b1 : count - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - directed table-driven bench for prog_mod_counter
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = '0;
  logic       max_we = 1'b0;
  logic [7:0] max_value = '0;
  logic       dir_up = 1'b1;
  logic       wrap_mode = 1'b1;
  logic [7:0] count;
  logic       tc;
  logic       halted;
`ifdef PRESCALER_EN
  logic [3:0] prescale = '0;
`endif

  int total = 0;
  int bad = 0;

  prog_mod_counter #(.NBIT(8), .DEFAULT_MAX(30), .PRESCALE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .max_we(max_we), .max_value(max_value),
    .dir_up(dir_up), .wrap_mode(wrap_mode),
`ifdef PRESCALER_EN
    .prescale(prescale),
`endif
    .count(count), .tc(tc), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       clr, ld;
    logic [7:0] lv;
    logic       mwe;
    logic [7:0] mv;
    logic       en, up, wrap;
    logic [7:0] ec;
    logic       etc, eh;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(logic clr_i, logic ld_i, logic [7:0] lv_i, logic mwe_i,
                              logic [7:0] mv_i, logic en_i, logic up_i, logic wrap_i,
                              logic [7:0] ec_i, logic etc_i, logic eh_i);
    vec_t v;
    v.clr = clr_i; v.ld = ld_i; v.lv = lv_i; v.mwe = mwe_i; v.mv = mv_i;
    v.en = en_i; v.up = up_i; v.wrap = wrap_i; v.ec = ec_i; v.etc = etc_i; v.eh = eh_i;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, got, exp);
    end
  endtask

  task automatic cyc(input logic clr_i, input logic ld_i, input logic [7:0] lv_i,
                     input logic mwe_i, input logic [7:0] mv_i, input logic en_i,
                     input logic up_i, input logic wrap_i);
    clear = clr_i; load = ld_i; load_value = lv_i; max_we = mwe_i; max_value = mv_i;
    enable = en_i; dir_up = up_i; wrap_mode = wrap_i;
    @(posedge clk);
    #1;
    clear = 1'b0; load = 1'b0; max_we = 1'b0; enable = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = mk(0, 0, 0,  0, 0,  0, 1, 1,  0, 0, 0);
    vt[1]  = mk(0, 1, 20, 0, 0,  0, 1, 1, 20, 0, 0);
    vt[2]  = mk(0, 0, 0,  1, 10, 0, 1, 1, 10, 0, 0);
    vt[3]  = mk(0, 0, 0,  0, 0,  1, 1, 1,  0, 1, 0);
    vt[4]  = mk(0, 0, 0,  0, 0,  1, 1, 1,  1, 0, 0);
    vt[5]  = mk(0, 0, 0,  0, 0,  1, 0, 1,  0, 0, 0);
    vt[6]  = mk(0, 0, 0,  0, 0,  1, 0, 1, 10, 1, 0);
    vt[7]  = mk(1, 1, 5,  0, 0,  1, 1, 1,  0, 0, 0);
    vt[8]  = mk(0, 0, 0,  1, 30, 0, 1, 1,  0, 0, 0);
    vt[9]  = mk(0, 1, 40, 0, 0,  0, 1, 1, 30, 0, 0);
    vt[10] = mk(0, 1, 40, 1, 12, 0, 1, 1, 12, 0, 0);
    vt[11] = mk(0, 0, 0,  0, 0,  1, 1, 0, 12, 1, 1);
    vt[12] = mk(0, 0, 0,  0, 0,  1, 0, 0, 12, 0, 1);
    vt[13] = mk(1, 0, 0,  0, 0,  0, 1, 0,  0, 0, 0);
    vt[14] = mk(0, 0, 0,  1, 0,  0, 1, 1,  0, 0, 0);
    vt[15] = mk(0, 0, 0,  0, 0,  1, 1, 1,  0, 1, 0);
    vt[16] = mk(0, 0, 0,  0, 0,  1, 0, 1,  0, 1, 0);
    vt[17] = mk(0, 0, 0,  0, 0,  1, 0, 0,  0, 1, 1);
    vt[18] = mk(0, 1, 9,  0, 0,  0, 1, 1,  0, 0, 0);
    vt[19] = mk(0, 0, 0,  1, 30, 1, 1, 1,  1, 0, 0);

    // reset state
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", 0, count, 0);
    chk("rst_tc", 0, tc, 0);
    chk("rst_halted", 0, halted, 0);

    // full up-count with wrap at MAX=30
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 1, 1);
      chk("upwrap_count", k, count, k % 31);
      chk("upwrap_tc", k, tc, (k == 31) ? 1 : 0);
    end

    // asynchronous reset mid-count, MAX returns to default
    cyc(0, 0, 0, 1, 12, 0, 1, 1);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 1, 1, 1);
    chk("pre_rst_count", 0, count, 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", 0, count, 0);
    chk("async_rst_tc", 0, tc, 0);
    chk("async_rst_halted", 0, halted, 0);
    #1 reset_n = 1'b1;
    cyc(0, 1, 40, 0, 0, 0, 1, 1);
    chk("rst_max_default", 0, count, 30);

    // down count into saturation
    cyc(0, 1, 3, 0, 0, 0, 0, 0);
    chk("sat_load", 0, count, 3);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 0, 0);
      chk("sat_count", k, count, (k < 3) ? 3 - k : 0);
      chk("sat_tc", k, tc, (k == 4) ? 1 : 0);
      chk("sat_halted", k, halted, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0, 0, 0, 1, k[0], 0);
      chk("halt_count", k, count, 0);
      chk("halt_tc", k, tc, 0);
      chk("halt_halted", k, halted, 1);
    end

    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(vt[i].clr, vt[i].ld, vt[i].lv, vt[i].mwe, vt[i].mv, vt[i].en, vt[i].up, vt[i].wrap);
      chk("vec_count", i, count, vt[i].ec);
      chk("vec_tc", i, tc, vt[i].etc);
      chk("vec_halted", i, halted, vt[i].eh);
    end

`ifdef PRESCALER_EN
    do_reset();
    prescale = 4'd2;
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 0, 0, 1, 1, 1);
      chk("presc_count", k, count, k / 3);
    end
    prescale = 4'd0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
